// File: rtl/fp_mult_arb.sv
// ---------------------------------------------------------------------------
// fp_mult_arb
//
// Purpose:
//   Shares one pipelined single-precision multiplier between two requesters.
//   A round-robin arbiter grants at most one operand pair per cycle and
//   issues it to the multiplier. A LATENCY-deep tag pipeline remembers which
//   requester owns each issue, so the result can be routed back as a
//   one-cycle response pulse. A flush drains all in-flight work, then spends
//   one CLEAR cycle (flush_done) before returning to RUN.
//
// Optional feature (macro FP_MULT_ARB_STICKY_EN):
//   defined   -> sticky_flags ORs in the flags of every response and is
//                cleared in the CLEAR state.
//   undefined -> sticky_flags is tied to 0 and flush only drains.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid/reqN_ready    requester handshake (N = 0,1)
//   reqN_a, reqN_b           requester operands (IEEE-754 single)
//   mul_valid, mul_a, mul_b  issue strobe and operands to the multiplier
//   mul_z, mul_flags         multiplier result, LATENCY cycles after issue
//   rspN_valid               one-cycle response pulse to requester N
//   rsp_z, rsp_flags         shared registered response bus
//   flush, flush_done        drain request / completion pulse
//   busy                     not in RUN, or any operation in flight
//   sticky_flags             accumulated response flags
//   dbg_state                current FSM state (0 RUN, 1 DRAIN, 2 CLEAR)
//
// Handshake: a transfer happens at a rising edge of clk when reqN_valid and
// reqN_ready are both high. reqN_ready is combinational, never depends on
// itself, and is only high when reqN_valid is high; a requester must hold
// valid and its operands stable until the transfer. Responses have no
// backpressure.
// ---------------------------------------------------------------------------
module fp_mult_arb #(
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        mul_valid,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_z,
    input  logic [5:0]  mul_flags,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_z,
    output logic [5:0]  rsp_flags,
    input  logic        flush,
    output logic        flush_done,
    output logic        busy,
    output logic [5:0]  sticky_flags,
    output logic [1:0]  dbg_state
);

    // Counter must hold LATENCY ops in the tag pipe plus one in the
    // response register.
    localparam int CNT_W = $clog2(LATENCY + 2);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_rr_last;      // id of the last granted requester
    logic [LATENCY:1]   r_tag_v;
    logic [LATENCY:1]   r_tag_id;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rsp0_valid;
    logic               r_rsp1_valid;
    logic [31:0]        r_rsp_z;
    logic [5:0]         r_rsp_flags;

    logic               w_sel;
    logic               w_issue;
    logic               w_take;
    logic               w_rsp_any;

    // ------------------------------------------------------------------
    // Arbitration and issue
    // ------------------------------------------------------------------
    // With both valid, the requester not granted last wins; with only one
    // valid, ~req0_valid selects whichever one it is.
    assign w_sel = (req0_valid && req1_valid) ? ~r_rr_last : ~req0_valid;

    // rst gates the combinational outputs so they read 0 while reset is held.
    assign w_issue = !rst && (r_state == ST_RUN) && !flush
                     && (req0_valid || req1_valid);

    assign req0_ready = w_issue && !w_sel;
    assign req1_ready = w_issue &&  w_sel;
    assign mul_valid  = w_issue;
    assign mul_a      = w_issue ? (w_sel ? req1_a : req0_a) : 32'h0;
    assign mul_b      = w_issue ? (w_sel ? req1_b : req0_b) : 32'h0;

    // A tag at the last stage means mul_z/mul_flags belong to a real issue.
    assign w_take    = r_tag_v[LATENCY];
    assign w_rsp_any = r_rsp0_valid || r_rsp1_valid;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN:   if (flush) w_next_state = ST_DRAIN;
            ST_DRAIN: if (r_cnt == '0) w_next_state = ST_CLEAR;
            ST_CLEAR: w_next_state = ST_RUN;
            default:  w_next_state = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Round-robin pointer, tag pipeline, in-flight counter, responses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last    <= 1'b1;   // last = 1 so req0 wins the first tie
            r_tag_v      <= '0;
            r_tag_id     <= '0;
            r_cnt        <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_z      <= 32'h0;
            r_rsp_flags  <= 6'h0;
        end else begin
            if (w_issue) begin
                r_rr_last <= w_sel;
            end

            r_tag_v[1]  <= w_issue;
            r_tag_id[1] <= w_sel;
            for (int k = 2; k <= LATENCY; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end

            // An op leaves the count when its response pulse is shown.
            case ({w_issue, w_rsp_any})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase

            r_rsp0_valid <= w_take && !r_tag_id[LATENCY];
            r_rsp1_valid <= w_take &&  r_tag_id[LATENCY];
            if (w_take) begin
                r_rsp_z     <= mul_z;
                r_rsp_flags <= mul_flags;
            end
        end
    end

    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp_z      = r_rsp_z;
    assign rsp_flags  = r_rsp_flags;
    assign flush_done = (r_state == ST_CLEAR);
    assign busy       = (r_state != ST_RUN) || (r_cnt != '0);
    assign dbg_state  = r_state;

    // ------------------------------------------------------------------
    // Sticky status
    // ------------------------------------------------------------------
`ifdef FP_MULT_ARB_STICKY_EN
    logic [5:0] r_sticky;

    // Accumulates at the same edge that loads rsp_flags, so sticky_flags
    // already includes a response while its pulse is visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 6'h0;
        end else if (r_state == ST_CLEAR) begin
            r_sticky <= 6'h0;
        end else if (w_take) begin
            r_sticky <= r_sticky | mul_flags;
        end
    end

    assign sticky_flags = r_sticky;
`else
    assign sticky_flags = 6'h0;
`endif

endmodule

// File: tb/tb_fp_mult_arb.sv
// ---------------------------------------------------------------------------
// tb_fp_mult_arb
//
// Directed bench for fp_mult_arb with LATENCY = 3. A behavioural 3-stage
// multiplier returns z = a + b - 0x3F800000 (exact for power-of-two style
// operands with zero mantissa product terms) and flags = b[5:0]; when no
// issue reaches its last stage it drives 0xDEADBEEF / 0x3F, which the DUT
// must ignore. Inputs change at the falling edge; outputs are checked #1
// later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_fp_mult_arb;

    localparam int LAT = 3;

`ifdef FP_MULT_ARB_STICKY_EN
    localparam logic [5:0] EXP_STK_03 = 6'h03;
    localparam logic [5:0] EXP_STK_3F = 6'h3F;
`else
    localparam logic [5:0] EXP_STK_03 = 6'h00;
    localparam logic [5:0] EXP_STK_3F = 6'h00;
`endif

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        mul_valid;
    logic [31:0] mul_a, mul_b;
    logic [31:0] mul_z;
    logic [5:0]  mul_flags;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_z;
    logic [5:0]  rsp_flags;
    logic        flush;
    logic        flush_done;
    logic        busy;
    logic [5:0]  sticky_flags;
    logic [1:0]  dbg_state;

    int n_assert;
    int n_fail;
    int pulses;

    fp_mult_arb #(.LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req1_valid   (req1_valid),
        .req0_ready   (req0_ready),
        .req1_ready   (req1_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .mul_valid    (mul_valid),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_z        (mul_z),
        .mul_flags    (mul_flags),
        .rsp0_valid   (rsp0_valid),
        .rsp1_valid   (rsp1_valid),
        .rsp_z        (rsp_z),
        .rsp_flags    (rsp_flags),
        .flush        (flush),
        .flush_done   (flush_done),
        .busy         (busy),
        .sticky_flags (sticky_flags),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- multiplier model ----------------
    logic [LAT:1] m_v;
    logic [31:0]  m_a [1:LAT];
    logic [31:0]  m_b [1:LAT];

    always @(posedge clk) begin
        m_v[1] <= mul_valid;
        m_a[1] <= mul_a;
        m_b[1] <= mul_b;
        for (int k = 2; k <= LAT; k++) begin
            m_v[k] <= m_v[k-1];
            m_a[k] <= m_a[k-1];
            m_b[k] <= m_b[k-1];
        end
    end

    assign mul_z     = (m_v[LAT] === 1'b1) ? (m_a[LAT] + m_b[LAT] - 32'h3F800000) : 32'hDEADBEEF;
    assign mul_flags = (m_v[LAT] === 1'b1) ? m_b[LAT][5:0] : 6'h3F;

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    logic [31:0] exp_a [0:3];
    logic [31:0] exp_z [0:3];

    initial begin
        n_assert = 0;
        n_fail   = 0;
        pulses   = 0;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 32'h0; req0_b = 32'h0; req1_a = 32'h0; req1_b = 32'h0;
        flush = 1'b0;

        // ---- reset state, with requests pending ----
        repeat (4) cyc();
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_mul_valid", mul_valid, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_rsp0", rsp0_valid, 0);
        chk("rst_sticky", sticky_flags, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // ---- single op: 1.0 * 2.0, response 4 cycles after transfer ----
        cyc(); rst = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000; #1;
        chk("t1_ready0", req0_ready, 1);
        chk("t1_ready1", req1_ready, 0);
        chk("t1_mul_valid", mul_valid, 1);
        chk("t1_mul_a", mul_a, 32'h3F800000);
        chk("t1_mul_b", mul_b, 32'h40000000);
        cyc(); req0_valid = 1'b0; #1;
        chk("t1_mul_idle", mul_valid, 0);
        chk("t1_mul_idle_a", mul_a, 0);
        chk("t1_busy", busy, 1);
        chk("t1_rsp0_c1", rsp0_valid, 0);
        cyc(); #1; chk("t1_rsp0_c2", rsp0_valid, 0);
        cyc(); #1; chk("t1_rsp0_c3", rsp0_valid, 0);
        cyc(); #1;
        chk("t1_rsp0_c4", rsp0_valid, 1);
        chk("t1_rsp1_c4", rsp1_valid, 0);
        chk("t1_rsp_z", rsp_z, 32'h40000000);
        chk("t1_rsp_flags", rsp_flags, 6'h00);
        cyc(); #1;
        chk("t1_rsp0_c5", rsp0_valid, 0);
        chk("t1_busy_idle", busy, 0);

        // ---- both valid for 4 cycles from reset: 0,1,0,1 ----
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        exp_a[0] = 32'h3F800000; exp_z[0] = 32'h40000000;
        exp_a[1] = 32'h40000000; exp_z[1] = 32'h40C00000;
        exp_a[2] = 32'h3F800000; exp_z[2] = 32'h40000000;
        exp_a[3] = 32'h40000000; exp_z[3] = 32'h40C00000;
        req0_a = 32'h3F800000; req0_b = 32'h40000000;
        req1_a = 32'h40000000; req1_b = 32'h40400000;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            #1;
            chk($sformatf("t2_ready0_%0d", i), req0_ready, (i % 2 == 0));
            chk($sformatf("t2_ready1_%0d", i), req1_ready, (i % 2 == 1));
            chk($sformatf("t2_mul_valid_%0d", i), mul_valid, 1);
            chk($sformatf("t2_mul_a_%0d", i), mul_a, exp_a[i]);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            req0_valid = 1'b0; req1_valid = 1'b0; #1;
            chk($sformatf("t2_rsp0_%0d", i), rsp0_valid, (i % 2 == 0));
            chk($sformatf("t2_rsp1_%0d", i), rsp1_valid, (i % 2 == 1));
            chk($sformatf("t2_rsp_z_%0d", i), rsp_z, exp_z[i]);
        end
        repeat (2) cyc();

        // ---- two in flight, then flush ----
        cyc(); req0_valid = 1'b1; #1;                              // C0
        chk("t3_ready0_c0", req0_ready, 1);
        cyc(); req0_valid = 1'b0; req1_valid = 1'b1; #1;           // C1
        chk("t3_ready1_c1", req1_ready, 1);
        cyc(); req1_valid = 1'b0; req0_valid = 1'b1; flush = 1'b1; #1; // C2
        chk("t3_flush_ready0", req0_ready, 0);
        chk("t3_flush_mul_valid", mul_valid, 0);
        cyc(); flush = 1'b0; #1;                                   // C3
        chk("t3_drain_ready0", req0_ready, 0);
        chk("t3_drain_busy", busy, 1);
        chk("t3_drain_state", dbg_state, 2'd1);
        req0_valid = 1'b0;
        cyc(); flush = 1'b1; #1;                                   // C4
        chk("t3_rsp0", rsp0_valid, 1);
        chk("t3_rsp0_z", rsp_z, 32'h40000000);
        cyc(); flush = 1'b0; #1;                                   // C5
        chk("t3_rsp1", rsp1_valid, 1);
        chk("t3_rsp1_z", rsp_z, 32'h40C00000);
        chk("t3_busy_c5", busy, 1);
        cyc(); #1;                                                 // C6
        chk("t3_flush_done_c6", flush_done, 0);
        chk("t3_busy_c6", busy, 1);
        cyc(); flush = 1'b1; #1;                                   // C7
        chk("t3_flush_done_c7", flush_done, 1);
        chk("t3_busy_c7", busy, 1);
        chk("t3_clear_state", dbg_state, 2'd2);
        cyc(); flush = 1'b0; #1;                                   // C8
        chk("t3_flush_done_c8", flush_done, 0);
        chk("t3_busy_c8", busy, 0);
        chk("t3_run_state", dbg_state, 2'd0);

        // ---- sticky flags 0x02 then 0x01 ----
        cyc(); req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000002; #1;
        chk("t4_ready0", req0_ready, 1);
        cyc(); req0_valid = 1'b0; req1_valid = 1'b1;
        req1_a = 32'h3F800000; req1_b = 32'h40000001; #1;
        chk("t4_ready1", req1_ready, 1);
        cyc(); req1_valid = 1'b0;
        cyc();
        cyc(); #1;
        chk("t4_rsp0", rsp0_valid, 1);
        chk("t4_rsp_flags_02", rsp_flags, 6'h02);
        cyc(); #1;
        chk("t4_rsp1", rsp1_valid, 1);
        chk("t4_rsp_flags_01", rsp_flags, 6'h01);
        cyc(); #1;
        chk("t4_sticky_03", sticky_flags, EXP_STK_03);
        flush = 1'b1;
        cyc(); flush = 1'b0;
        for (int k = 0; k < 10 && flush_done !== 1'b1; k++) begin
            cyc(); #1;
        end
        chk("t4_flush_done_seen", flush_done, 1);
        cyc(); #1;
        chk("t4_sticky_cleared", sticky_flags, 6'h00);

        // ---- response with all flags set ----
        cyc(); req0_valid = 1'b1; req0_b = 32'h4000003F;
        cyc(); req0_valid = 1'b0;
        cyc();
        cyc();
        cyc(); #1;
        chk("t5_rsp0", rsp0_valid, 1);
        chk("t5_rsp_flags_3f", rsp_flags, 6'h3F);
        cyc(); #1;
        chk("t5_sticky", sticky_flags, EXP_STK_3F);
        cyc(); flush = 1'b1;
        cyc(); flush = 1'b0;
        repeat (4) cyc();
        #1;
        chk("t5_back_to_run", dbg_state, 2'd0);

        // ---- reset with 3 ops in flight ----
        req0_b = 32'h40000000;
        cyc(); req0_valid = 1'b1; req1_valid = 1'b1;
        cyc();
        cyc();
        cyc(); rst = 1'b1; #1;
        chk("t6_rst_ready0", req0_ready, 0);
        chk("t6_rst_ready1", req1_ready, 0);
        chk("t6_rst_mul_valid", mul_valid, 0);
        chk("t6_rst_mul_b", mul_b, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rsp_z", rsp_z, 0);
        chk("t6_rst_rsp_flags", rsp_flags, 0);
        chk("t6_rst_sticky", sticky_flags, 0);
        chk("t6_rst_state", dbg_state, 2'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc(); #1;
        chk("t6_rst_rsp0_held", rsp0_valid, 0);
        chk("t6_rst_rsp1_held", rsp1_valid, 0);
        cyc(); rst = 1'b0;
        req1_valid = 1'b1; req1_a = 32'h40000000; req1_b = 32'h40000000; #1;
        chk("t6_first_ready1", req1_ready, 1);
        chk("t6_first_mul_a", mul_a, 32'h40000000);
        pulses = pulses + int'(rsp0_valid | rsp1_valid);
        for (int k = 0; k < 3; k++) begin
            cyc(); req1_valid = 1'b0; #1;
            pulses = pulses + int'(rsp0_valid | rsp1_valid);
        end
        chk("t6_no_stale_rsp", pulses, 0);
        cyc(); #1;
        chk("t6_rsp1", rsp1_valid, 1);
        chk("t6_rsp0", rsp0_valid, 0);
        chk("t6_rsp_z", rsp_z, 32'h40800000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_mult_arb.md
FP_MULT_ARB -- requirements
Module: fp_mult_arb

Interface
REQ-001 Parameter LATENCY, default 3, range 1..8: cycles from mul_valid to the multiplier result on mul_z/mul_flags.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid, req1_valid  input  1 each  requester operand pair valid.
REQ-005 req0_ready, req1_ready  output  1 each  grant; a transfer occurs when valid&&ready is high at a clk edge.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  32 each  IEEE-754 single operands.
REQ-007 mul_valid  output  1  issue strobe to the shared multiplier.
REQ-008 mul_a, mul_b  output  32 each  issued operands.
REQ-009 mul_z  input  32  multiplier result.
REQ-010 mul_flags  input  6  {zero,inf,nan,tiny,huge,inexact}, bit5..bit0.
REQ-011 rsp0_valid, rsp1_valid  output  1 each  one-cycle response pulse to the owning requester.
REQ-012 rsp_z  output  32; rsp_flags  output  6  shared response bus, meaningful only while a rsp valid is high.
REQ-013 flush  input  1  request drain-and-clear.
REQ-014 flush_done  output  1  one-cycle pulse at completion of a flush.
REQ-015 busy  output  1  high when state is not RUN or any operation is in flight.
REQ-016 sticky_flags  output  6  accumulated status (see Configuration).

Function
REQ-017 The block SHALL grant at most one requester per cycle, and only in state RUN.
REQ-018 reqN_ready SHALL be combinational: high only for the requester selected this cycle, and only when its valid is high.
REQ-019 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins; with one valid, that one wins; the pointer updates only on a transfer.
REQ-020 On a transfer, mul_valid SHALL be high in the same cycle with mul_a/mul_b equal to the granted operands; otherwise mul_valid=0 and mul_a=mul_b=0.
REQ-021 A LATENCY-deep tag shift register SHALL carry {valid,id} for each issue; when a tag reaches stage LATENCY, mul_z/mul_flags SHALL be sampled into registered rsp_z/rsp_flags.
REQ-022 rspN_valid SHALL pulse exactly LATENCY+1 cycles after the transfer edge, for the id in the tag; mul_z/mul_flags with no matching tag SHALL be ignored.
REQ-023 Back-to-back issues SHALL be supported every cycle; responses SHALL return in issue order; there is no response backpressure.
REQ-024 The in-flight counter (0..LATENCY+1) SHALL increment on issue, decrement on response, and remain unchanged when both occur in one cycle.
REQ-025 FSM states SHALL be RUN, DRAIN and CLEAR.
REQ-026 RUN to DRAIN on flush=1; flush SHALL take priority over a concurrent request, with no grant in that cycle.
REQ-027 DRAIN to CLEAR when the in-flight count is 0.
REQ-028 CLEAR to RUN unconditionally after one cycle; flush_done SHALL be high during CLEAR.
REQ-029 flush SHALL be ignored in DRAIN and CLEAR.
REQ-030 Responses SHALL still be delivered during DRAIN.

Reset
REQ-031 Asserting rst SHALL force state RUN, round-robin pointer favouring req0, tag pipeline and counter cleared, and all outputs 0 (sticky_flags 0); operations in flight at reset SHALL be discarded with no rsp pulse.
REQ-032 Outputs SHALL remain 0 while rst is held; the first grant is possible in the first cycle after deassertion.

Configuration
REQ-033 With macro FP_MULT_ARB_STICKY_EN defined, sticky_flags SHALL OR in rsp_flags on every response and clear to 0 in CLEAR.
REQ-034 Without FP_MULT_ARB_STICKY_EN, sticky_flags SHALL be tied to 0 and flush SHALL only drain.

Verification
REQ-035 LATENCY=3; req0 a=0x3F800000, b=0x40000000; model returns 0x40000000 with flags 0 -> rsp0_valid 4 cycles after the transfer, rsp_z=0x40000000, rsp_flags=0.
REQ-036 Both requesters valid for 4 cycles from reset -> grants 0,1,0,1; responses arrive in the same order; mul_valid high for 4 consecutive cycles.
REQ-037 Two ops in flight, then flush -> ready low from the flush cycle; two rsp pulses; then a flush_done pulse; busy stays high until RUN.
REQ-038 STICKY_EN defined; responses with flags 0x02 then 0x01 -> sticky_flags=0x03; after flush -> 0x00.
REQ-039 rst asserted with 3 ops in flight -> no rsp pulses afterwards; all outputs 0; next req1 issue is granted normally.
REQ-040 STICKY_EN undefined; a response with flags 0x3F -> sticky_flags stays 0x00.
